muldiv_seq_ctrl: RTL and testbench
==================================

// Module: muldiv_seq_ctrl
// PURPOSE
//  Execute-stage sequencer for RV32M ops (rtype opcode with funct7 bit0 set), which the main decoder does not route to the ALU.
//  Captures operands, starts the shared iterative multiplier or divider, and stalls F/D/E until the result is available.
//  Resolves divide-by-zero and signed overflow without using the divider. Drains an in-flight op after a flush.
// PARAMETERS
//  XLEN   32   datapath width
// PORTS
//  clk             in   1       core clock
//  resetn          in   1       async active-low reset
//  MulDivOpE       in   1       valid M-extension instruction in EX
//  funct3E         in   3       M-op select
//  SrcAE           in   XLEN    rs1 value (forwarded)
//  SrcBE           in   XLEN    rs2 value (forwarded)
//  FlushE          in   1       kill the EX instruction
//  mul_start_o     out  1       1-cycle start pulse to multiplier
//  mul_op_o        out  2       funct3[1:0]: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//  mul_a_o/mul_b_o out  XLEN    latched operands (shared with divider)
//  mul_done_i      in   1       1-cycle completion pulse
//  mul_prod_i      in   2*XLEN  full product, valid with mul_done_i
//  div_start_o     out  1       1-cycle start pulse to divider
//  div_signed_o    out  1       ~funct3[0]
//  div_done_i      in   1       1-cycle completion pulse
//  div_quot_i      in   XLEN    quotient, valid with div_done_i
//  div_rem_i       in   XLEN    remainder, valid with div_done_i
//  StallMdE        out  1       stall F/D/E (combinational)
//  MdResultE       out  XLEN    result register
//  MdResultValidE  out  1       result valid, EX advances this cycle
// BEHAVIOUR
//  Reset: state IDLE; op/operand/result regs 0; all start/valid outputs 0.
//  States: IDLE, MUL_WAIT, DIV_WAIT, DONE, DRAIN.
//  IDLE, MulDivOpE & !FlushE:
//    Latch funct3, SrcAE, SrcBE.
//    DIV/DIVU with B==0: result all-ones. REM/REMU with B==0: result A. -> DONE.
//    DIV with A==0x80000000, B==-1: result 0x80000000. REM with the same operands: result 0. -> DONE.
//    Other funct3[2]==0 ops: pulse mul_start_o next cycle -> MUL_WAIT.
//    Other funct3[2]==1 ops: pulse div_start_o next cycle -> DIV_WAIT.
//  Start pulses: registered, high exactly 1 cycle (the first cycle of the WAIT state). Operands hold until leaving WAIT/DRAIN.
//  MUL_WAIT on mul_done_i: MUL takes prod[XLEN-1:0]; MULH/MULHSU/MULHU take prod[2XLEN-1:XLEN] -> DONE.
//  DIV_WAIT on div_done_i: DIV/DIVU take quot; REM/REMU take rem -> DONE.
//  DONE: MdResultValidE = !FlushE. StallMdE=0. Always -> IDLE next cycle; the still-present op is not restarted.
//  StallMdE = (IDLE & MulDivOpE & !FlushE) | MUL_WAIT | DIV_WAIT | (DRAIN & MulDivOpE).
//  FlushE in MUL_WAIT or DIV_WAIT: -> DRAIN; StallMdE drops that cycle.
//  DRAIN: wait for the pending unit's done pulse, discard the result, -> IDLE.
//    A new M-op arriving during DRAIN is stalled, then starts from IDLE.
//  done pulses in IDLE, DONE, or from the non-pending unit: ignored.
//  done pulse in the same cycle as start: illegal; units guarantee >=1 cycle latency.
//  Latency from EX entry: fast path = 1 stall cycle, result on cycle 2.
//    Unit path = N+1 stall cycles for unit latency N; MdResultValidE one cycle after done.
//  Async reset mid-operation returns to IDLE. No start is reissued. A later done pulse is ignored.
// TESTING
//  1. MUL A=7, B=0xFFFFFFFD, mul done after 3 cycles -> 0xFFFFFFEB. Stall high 4 cycles. 1 valid pulse.
//  2. MULHU A=B=0xFFFFFFFF -> 0xFFFFFFFE. mul_op_o=11.
//  3. DIVU by 0 -> 0xFFFFFFFF with no div_start_o. REM 0x80000000 % -1 -> 0.
//  4. Flush during DIV_WAIT, then MUL enters EX before div_done_i -> stall until done+1, then MUL starts and completes.
//  5. resetn low during MUL_WAIT, late mul_done_i -> stays IDLE, no MdResultValidE.
//  6. Back-to-back DIV, MUL with no bubble -> two starts, no restart of either op, results in order.

Source files
------------

// File: rtl/muldiv_seq_ctrl.sv
// Execute-stage sequencer for RV32M ops: captures operands, runs the shared
// iterative multiplier/divider, resolves divide special cases locally, drains after flush.
module muldiv_seq_ctrl #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              MulDivOpE,
  input  logic [2:0]        funct3E,
  input  logic [XLEN-1:0]   SrcAE,
  input  logic [XLEN-1:0]   SrcBE,
  input  logic              FlushE,
  output logic              mul_start_o,
  output logic [1:0]        mul_op_o,
  output logic [XLEN-1:0]   mul_a_o,
  output logic [XLEN-1:0]   mul_b_o,
  input  logic              mul_done_i,
  input  logic [2*XLEN-1:0] mul_prod_i,
  output logic              div_start_o,
  output logic              div_signed_o,
  input  logic              div_done_i,
  input  logic [XLEN-1:0]   div_quot_i,
  input  logic [XLEN-1:0]   div_rem_i,
  output logic              StallMdE,
  output logic [XLEN-1:0]   MdResultE,
  output logic              MdResultValidE
);

  // state    | meaning
  // IDLE     | no op in flight; accepts a new M-op from EX
  // MUL_WAIT | multiplier running, waiting for mul_done_i
  // DIV_WAIT | divider running, waiting for div_done_i
  // DONE     | result register valid for one cycle, EX advances
  // DRAIN    | op was flushed; swallow the pending unit's done pulse
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MUL_WAIT = 3'd1,
    S_DIV_WAIT = 3'd2,
    S_DONE     = 3'd3,
    S_DRAIN    = 3'd4
  } state_t;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            r_state;
  logic [2:0]        r_funct3;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_result;
  logic              r_mul_start;
  logic              r_div_start;

  logic              w_accept;
  logic              w_is_div;
  logic              w_b_zero;
  logic              w_ovf;
  logic              w_fast;
  logic [XLEN-1:0]   w_fast_res;
  logic              w_pending_done;

  assign w_accept = (r_state == S_IDLE) && MulDivOpE && !FlushE;
  assign w_is_div = funct3E[2];
  assign w_b_zero = (SrcBE == '0);
  assign w_ovf    = !funct3E[0] && (SrcAE == MOST_NEG) && (SrcBE == '1);
  assign w_fast   = w_is_div && (w_b_zero || w_ovf);

  // funct3[1] separates REM/REMU from DIV/DIVU
  always_comb begin
    w_fast_res = '0;
    if (w_b_zero) begin
      w_fast_res = funct3E[1] ? SrcAE : '1;
    end else begin
      w_fast_res = funct3E[1] ? '0 : MOST_NEG;
    end
  end

  // In DRAIN the latched funct3 still tells which unit owes a done pulse
  assign w_pending_done = r_funct3[2] ? div_done_i : mul_done_i;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_funct3    <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_result    <= '0;
      r_mul_start <= 1'b0;
      r_div_start <= 1'b0;
    end else begin
      r_mul_start <= 1'b0;
      r_div_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_funct3 <= funct3E;
            r_a      <= SrcAE;
            r_b      <= SrcBE;
            if (w_fast) begin
              r_result <= w_fast_res;
              r_state  <= S_DONE;
            end else if (w_is_div) begin
              r_div_start <= 1'b1;
              r_state     <= S_DIV_WAIT;
            end else begin
              r_mul_start <= 1'b1;
              r_state     <= S_MUL_WAIT;
            end
          end
        end
        S_MUL_WAIT: begin
          // A flush coinciding with done has nothing left to drain
          if (FlushE) begin
            r_state <= mul_done_i ? S_IDLE : S_DRAIN;
          end else if (mul_done_i) begin
            r_result <= (r_funct3[1:0] == 2'b00) ? mul_prod_i[XLEN-1:0]
                                                 : mul_prod_i[2*XLEN-1:XLEN];
            r_state  <= S_DONE;
          end
        end
        S_DIV_WAIT: begin
          if (FlushE) begin
            r_state <= div_done_i ? S_IDLE : S_DRAIN;
          end else if (div_done_i) begin
            r_result <= r_funct3[1] ? div_rem_i : div_quot_i;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        S_DRAIN: begin
          if (w_pending_done) r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mul_start_o    = r_mul_start;
  assign div_start_o    = r_div_start;
  assign mul_op_o       = r_funct3[1:0];
  assign div_signed_o   = ~r_funct3[0];
  assign mul_a_o        = r_a;
  assign mul_b_o        = r_b;
  assign MdResultE      = r_result;
  assign MdResultValidE = (r_state == S_DONE) && !FlushE;

  assign StallMdE = w_accept
                 || (((r_state == S_MUL_WAIT) || (r_state == S_DIV_WAIT)) && !FlushE)
                 || ((r_state == S_DRAIN) && MulDivOpE);

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Bench for muldiv_seq_ctrl: behavioural multiplier/divider units plus an
// arithmetic RV32M reference; directed scenarios followed by randomized op streams.
module tb_muldiv_seq_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        MulDivOpE;
  logic [2:0]  funct3E;
  logic [31:0] SrcAE, SrcBE;
  logic        FlushE;
  logic        mul_start_o;
  logic [1:0]  mul_op_o;
  logic [31:0] mul_a_o, mul_b_o;
  logic        mul_done_i;
  logic [63:0] mul_prod_i;
  logic        div_start_o, div_signed_o;
  logic        div_done_i;
  logic [31:0] div_quot_i, div_rem_i;
  logic        StallMdE;
  logic [31:0] MdResultE;
  logic        MdResultValidE;

  int n_checks = 0;
  int n_fail   = 0;
  int mul_lat  = 2;
  int div_lat  = 3;
  int mul_starts = 0;
  int div_starts = 0;

  muldiv_seq_ctrl #(.XLEN(32)) dut (
    .clk(clk), .resetn(resetn), .MulDivOpE(MulDivOpE), .funct3E(funct3E),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .FlushE(FlushE),
    .mul_start_o(mul_start_o), .mul_op_o(mul_op_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
    .mul_done_i(mul_done_i), .mul_prod_i(mul_prod_i),
    .div_start_o(div_start_o), .div_signed_o(div_signed_o),
    .div_done_i(div_done_i), .div_quot_i(div_quot_i), .div_rem_i(div_rem_i),
    .StallMdE(StallMdE), .MdResultE(MdResultE), .MdResultValidE(MdResultValidE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int sa, sb;
    sa = a;
    sb = b;
    case (f3)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
      3'd2: begin p = longint'(sa) * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return sa / sb;
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && (b == 0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  // Multiplier unit model: done pulse lat cycles after the start cycle
  initial begin
    int cnt = 0;
    logic [63:0] xa, xb;
    mul_done_i = 0;
    mul_prod_i = '0;
    forever begin
      @(negedge clk);
      mul_done_i = 0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) mul_done_i = 1;
      end
      if (mul_start_o) begin
        mul_starts++;
        cnt = mul_lat;
        xa = (mul_op_o == 2'd1 || mul_op_o == 2'd2) ? {{32{mul_a_o[31]}}, mul_a_o} : {32'b0, mul_a_o};
        xb = (mul_op_o == 2'd1) ? {{32{mul_b_o[31]}}, mul_b_o} : {32'b0, mul_b_o};
        mul_prod_i = xa * xb;
      end
    end
  end

  initial begin
    int cnt = 0;
    int qa, qb;
    div_done_i = 0;
    div_quot_i = '0;
    div_rem_i  = '0;
    forever begin
      @(negedge clk);
      div_done_i = 0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) div_done_i = 1;
      end
      if (div_start_o) begin
        div_starts++;
        cnt = div_lat;
        qa = mul_a_o;
        qb = mul_b_o;
        if (mul_b_o == 0) begin
          div_quot_i = '0; div_rem_i = '0;
        end else if (div_signed_o) begin
          div_quot_i = qa / qb; div_rem_i = qa % qb;
        end else begin
          div_quot_i = mul_a_o / mul_b_o; div_rem_i = mul_a_o % mul_b_o;
        end
      end
    end
  end

  // Present one op from the next negedge and follow it to its valid cycle
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input int exp_stall);
    int stalls = 0;
    bit got = 0;
    int m0 = mul_starts;
    int d0 = div_starts;
    bit fast = is_fast(f3, a, b);
    @(negedge clk);
    MulDivOpE = 1; funct3E = f3; SrcAE = a; SrcBE = b; FlushE = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (cyc > 0) @(negedge clk);
      #1;
      if (MdResultValidE) begin
        got = 1;
        break;
      end
      if (!StallMdE) break;
      stalls++;
    end
    chk({tag, "_valid_seen"}, got, 1);
    chk({tag, "_stall_cycles"}, stalls, exp_stall);
    chk({tag, "_result"}, MdResultE, ref_md(f3, a, b));
    chk({tag, "_mul_starts"}, mul_starts - m0, (!fast && !f3[2]) ? 1 : 0);
    chk({tag, "_div_starts"}, div_starts - d0, (!fast && f3[2]) ? 1 : 0);
    chk({tag, "_opnd_a"}, mul_a_o, a);
    if (!fast && !f3[2]) chk({tag, "_mul_op"}, mul_op_o, f3[1:0]);
    if (!fast && f3[2])  chk({tag, "_div_signed"}, div_signed_o, !f3[0]);
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge clk);
    MulDivOpE = 0; FlushE = 0;
    #1;
    chk({tag, "_idle_valid"}, MdResultValidE, 0);
    chk({tag, "_idle_stall"}, StallMdE, 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int m0, vcount;
    logic [2:0] rf;
    logic [31:0] ra, rb;
    resetn = 0; MulDivOpE = 0; funct3E = 0; SrcAE = 0; SrcBE = 0; FlushE = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_result", MdResultE, 0);
    chk("rst_valid", MdResultValidE, 0);
    chk("rst_stall", StallMdE, 0);
    chk("rst_starts", {mul_start_o, div_start_o}, 0);
    chk("rst_opnd", {mul_a_o, mul_b_o}, 0);
    resetn = 1;

    mul_lat = 2;
    run_op("t1_mul", 3'd0, 32'd7, 32'hFFFFFFFD, 4);
    idle_cycle("t1");
    mul_lat = 3;
    run_op("t2_mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5);
    idle_cycle("t2");
    run_op("t3_divu0", 3'd5, 32'h1234, 32'h0, 1);
    run_op("t3_removf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 1);
    run_op("t3_divovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 1);
    run_op("t3_rem0", 3'd6, 32'hDEADBEEF, 32'h0, 1);
    idle_cycle("t3");

    // Flush while the divider is busy, then a MUL waits out the drain
    div_lat = 6; mul_lat = 2;
    @(negedge clk);
    MulDivOpE = 1; funct3E = 3'd4; SrcAE = 32'd100; SrcBE = 32'd7; FlushE = 0;
    #1 chk("t4_idle_stall", StallMdE, 1);
    @(negedge clk);
    #1 chk("t4_div_start", div_start_o, 1);
    @(negedge clk);
    FlushE = 1;
    #1;
    chk("t4_flush_stall", StallMdE, 0);
    chk("t4_flush_valid", MdResultValidE, 0);
    run_op("t4_mul_after_drain", 3'd0, 32'd9, 32'd11, 6 - 1 + 2 + 2);
    idle_cycle("t4");

    // Reset mid-multiply; the late done must not produce a result
    mul_lat = 5;
    @(negedge clk);
    MulDivOpE = 1; funct3E = 3'd1; SrcAE = 32'd5; SrcBE = 32'd6;
    @(negedge clk);
    #1 chk("t5_mul_start", mul_start_o, 1);
    m0 = mul_starts;
    @(negedge clk);
    resetn = 0; MulDivOpE = 0;
    #1 chk("t5_rst_stall", StallMdE, 0);
    @(negedge clk);
    resetn = 1;
    vcount = 0;
    repeat (8) begin
      @(negedge clk);
      #1 if (MdResultValidE || StallMdE) vcount++;
    end
    chk("t5_no_activity", vcount, 0);
    chk("t5_no_restart", mul_starts - m0, 0);
    chk("t5_result_cleared", MdResultE, 0);
    run_op("t5_after_rst", 3'd5, 32'd1, 32'd0, 1);

    div_lat = 4; mul_lat = 3;
    run_op("t6_div", 3'd4, 32'hFFFFFF9C, 32'd7, 6);
    run_op("t6_mul", 3'd0, 32'h00012345, 32'h00000100, 5);
    idle_cycle("t6");

    // Flush in DONE suppresses the valid pulse
    @(negedge clk);
    MulDivOpE = 1; funct3E = 3'd7; SrcAE = 32'd3; SrcBE = 32'd0;
    @(negedge clk);
    FlushE = 1;
    #1 chk("t7_done_flush_valid", MdResultValidE, 0);
    idle_cycle("t7");

    for (int i = 0; i < 60; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = pick();
      rb = ($urandom_range(0, 3) == 0) ? 32'h0 : pick();
      mul_lat = $urandom_range(1, 5);
      div_lat = $urandom_range(1, 5);
      run_op("rnd", rf, ra, rb,
             is_fast(rf, ra, rb) ? 1 : ((rf[2] ? div_lat : mul_lat) + 2));
      if ($urandom_range(0, 1) == 1) idle_cycle("rnd");
    end
    idle_cycle("end");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
